// File: rtl/dsm_cic_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : dsm_cic_decimator
//  Purpose  : Third-order CIC (sinc^3) decimator for a 1-bit delta-sigma
//             bitstream. Bits map to +1/-1, run through three pipelined
//             integrators at the fast rate, are sampled every R accepted bits,
//             and pass through a three-stage comb. The result is a signed
//             ACC_W-bit sample at the slow rate with a DC gain of R^3.
//  Ports    : clock      - fast clock
//             reset      - synchronous, active-low reset
//             bit_in     - modulator bit (1 => +1, 0 => -1)
//             bit_valid  - qualifies bit_in; filter state holds when low
//             dout       - decimated sample, two's complement
//             dout_valid - one-cycle pulse when dout is new (after warm-up)
//             settled    - high once warm-up is done, until the next reset
//  Revision : 1.0 - initial release
// ============================================================================
module dsm_cic_decimator #(
    parameter int R     = 50,
    parameter int ACC_W = 20,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [ACC_W-1:0] dout,
    output logic             dout_valid,
    output logic             settled
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [1:0]       WARM_DONE = 2'd3;

    // Input mapped to +1 / -1 at full accumulator width.
    logic [ACC_W-1:0] x;
    assign x = bit_in ? ACC_W'(1) : {ACC_W{1'b1}};

    // Integrator chain. All arithmetic wraps modulo 2^ACC_W on purpose: the
    // comb differences recover the correct value as long as ACC_W covers the
    // R^3 gain, so no saturation or overflow detection is wanted.
    logic [ACC_W-1:0] i1, i2, i3;

    // Decimation counter and sample strobe.
    logic [CNT_W-1:0] cnt;
    logic             strobe;
    assign strobe = bit_valid && (cnt == CNT_LAST);

    // Sample register plus a flag marking that the comb runs on the next edge.
    logic [ACC_W-1:0] samp;
    logic             comb_pending;

    // Comb delay line and combinational differences.
    logic [ACC_W-1:0] d1, d2, d3;
    logic [ACC_W-1:0] c1, c2, c3;
    assign c1 = samp - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // Counts the first comb updates after reset; the filter history is not
    // fully populated until the fourth update.
    logic [1:0] warm_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            i1           <= '0;
            i2           <= '0;
            i3           <= '0;
            cnt          <= '0;
            samp         <= '0;
            comb_pending <= 1'b0;
        end else begin
            if (bit_valid) begin
                // Pipelined: each stage sums the pre-edge value of the one before.
                i1  <= i1 + x;
                i2  <= i2 + i1;
                i3  <= i3 + i2;
                cnt <= (cnt == CNT_LAST) ? CNT_ZERO : cnt + 1'b1;
            end
            if (strobe) begin
                samp <= i3;
            end
            // R >= 2 guarantees a new strobe never coincides with this update.
            comb_pending <= strobe;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            settled    <= 1'b0;
            warm_cnt   <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (comb_pending) begin
                d1   <= samp;
                d2   <= c1;
                d3   <= c2;
                dout <= c3;
                if (warm_cnt == WARM_DONE) begin
                    dout_valid <= 1'b1;
                    settled    <= 1'b1;
                end else begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
